// File: rtl/alu_reservation_station_pkg.sv
// Shared widths, opcodes and bundle types for the
// ALU reservation station, decoder and ROB.
package alu_reservation_station_pkg;

  localparam int OPCODE_LENGTH = 6;
  localparam int REORDER_BUFFER_SIZE_LOG = 4;
  localparam int FUNCTION_UNIT_NUMBER = 16;
  localparam int FUNCTION_UNIT_NUMBER_LOG = 4;
  localparam int XLEN = 32;

  typedef logic [OPCODE_LENGTH-1:0] opcode_t;
  typedef logic [REORDER_BUFFER_SIZE_LOG-1:0] rob_pos_t;
  typedef logic [FUNCTION_UNIT_NUMBER_LOG-1:0] tag_t;
  typedef logic [XLEN-1:0] word_t;

  localparam opcode_t OPCODE_NOP  = 6'd0;
  localparam opcode_t OPCODE_ADD  = 6'd1;
  localparam opcode_t OPCODE_ADDI = 6'd2;
  localparam opcode_t OPCODE_SUB  = 6'd3;
  localparam opcode_t OPCODE_SUBI = 6'd4;
  localparam opcode_t OPCODE_MUL  = 6'd5;
  localparam opcode_t OPCODE_BGE  = 6'd6;
  localparam opcode_t OPCODE_SHL  = 6'd7;
  localparam opcode_t OPCODE_SHR  = 6'd8;

  typedef struct packed {
    logic     busy;
    rob_pos_t pos;
    word_t    value;
  } wb_t;

  // Tag 0 marks an operand that is already valid.
  function automatic word_t resolve(
    input tag_t  q,
    input word_t v,
    input word_t slot
  );
    return (q == '0) ? v : slot;
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Issue-side inputs, CDB and ROB write-back of the
// ALU reservation station.
interface alu_reservation_station_if;
  import alu_reservation_station_pkg::*;

  opcode_t  op;
  rob_pos_t pos;
  tag_t     qi;
  word_t    vi;
  tag_t     qj;
  word_t    vj;
  tag_t     qk;
  word_t    vk;
  logic [FUNCTION_UNIT_NUMBER*XLEN-1:0] commonDataBus;

  logic     busy;
  rob_pos_t writeBuffer_position;
  word_t    writeBuffer_value;

  modport master (
    output op, pos,
    output qi, vi, qj, vj, qk, vk,
    output commonDataBus,
    input  busy,
    input  writeBuffer_position,
    input  writeBuffer_value
  );

  modport slave (
    input  op, pos,
    input  qi, vi, qj, vj, qk, vk,
    input  commonDataBus,
    output busy,
    output writeBuffer_position,
    output writeBuffer_value
  );

endinterface

// File: rtl/alu_reservation_station_alu_core.sv
// Combinational integer ALU; valid flags a
// defined, non-NOP opcode.
module alu_core
  import alu_reservation_station_pkg::*;
(
  input  opcode_t op,
  input  word_t   a,
  input  word_t   b,
  output logic    valid,
  output word_t   result
);

  always_comb begin
    valid  = 1'b1;
    result = '0;
    unique case (1'b1)
      (op == OPCODE_ADD),
      (op == OPCODE_ADDI):
        result = a + b;
      (op == OPCODE_SUB),
      (op == OPCODE_SUBI):
        result = a - b;
      (op == OPCODE_MUL):
        result = a * b;
      // 0 means taken for the branch unit.
      (op == OPCODE_BGE):
        result = ($signed(a) >= $signed(b))
               ? 32'd0 : 32'd1;
      (op == OPCODE_SHL):
        result = a << b[4:0];
      (op == OPCODE_SHR):
        result = a >> b[4:0];
      default:
        valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Single-entry ALU reservation station: CDB operand
// forwarding, ALU, registered ROB write-back.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
(
  input logic clk,
  input logic reset,
  alu_reservation_station_if.slave rs
);

  word_t slot [FUNCTION_UNIT_NUMBER];
  word_t opa;
  word_t opb;
  word_t res;
  logic  issue;
  wb_t   wb;
  logic  unused_third;

  for (genvar t = 0; t < FUNCTION_UNIT_NUMBER;
       t++) begin : g_slot
    assign slot[t] =
      rs.commonDataBus[XLEN*t +: XLEN];
  end

  assign opa = resolve(rs.qj, rs.vj, slot[rs.qj]);
  assign opb = resolve(rs.qk, rs.vk, slot[rs.qk]);

  // The third operand only matters to other units.
  assign unused_third = ^{rs.qi, rs.vi};

  alu_core u_alu (
    .op     (rs.op),
    .a      (opa),
    .b      (opb),
    .valid  (issue),
    .result (res)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb <= '0;
    end else if (issue) begin
      wb.busy  <= 1'b1;
      wb.pos   <= rs.pos;
      wb.value <= res;
    end else begin
      wb.busy <= 1'b0;
    end
  end

  assign rs.busy                 = wb.busy;
  assign rs.writeBuffer_position = wb.pos;
  assign rs.writeBuffer_value    = wb.value;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Randomized and directed bench for the ALU
// reservation station against an arithmetic model.
module tb_alu_reservation_station;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] cdb [16];
  logic        exp_busy;
  logic [3:0]  exp_pos;
  logic [31:0] exp_val;

  alu_reservation_station_if rs_if ();

  alu_reservation_station dut (
    .clk   (clk),
    .reset (reset),
    .rs    (rs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(
    input int o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    case (o)
      1, 2: return a + b;
      3, 4: return a - b;
      5:    return prod[31:0];
      6:    return ($signed(a) >= $signed(b))
                   ? 32'd0 : 32'd1;
      7:    return a << (b % 32);
      8:    return a >> (b % 32);
      default: return 32'd0;
    endcase
  endfunction

  // Drive one cycle of issue and advance the model.
  task automatic drive(
    input int o, input int p,
    input int tj, input logic [31:0] j,
    input int tk, input logic [31:0] k
  );
    logic [31:0] a;
    logic [31:0] b;
    rs_if.op  = 6'(o);
    rs_if.pos = 4'(p);
    rs_if.qj  = 4'(tj);
    rs_if.vj  = j;
    rs_if.qk  = 4'(tk);
    rs_if.vk  = k;
    rs_if.qi  = 4'($urandom);
    rs_if.vi  = $urandom;
    for (int t = 0; t < 16; t++)
      rs_if.commonDataBus[t*32 +: 32] = cdb[t];
    a = (tj == 0) ? j : cdb[tj];
    b = (tk == 0) ? k : cdb[tk];
    if (!reset) begin
      exp_busy = 1'b0;
      exp_pos  = 4'd0;
      exp_val  = 32'd0;
    end else if (o >= 1 && o <= 8) begin
      exp_busy = 1'b1;
      exp_pos  = 4'(p);
      exp_val  = alu_model(o, a, b);
    end else begin
      exp_busy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(1, 9, 0, 5, 0, 7);
      checks++;
      if (rs_if.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy got %0b want 0",
                 rs_if.busy);
      end
      checks++;
      if (rs_if.writeBuffer_position !== 4'd0) begin
        errors++;
        $display("FAIL reset_pos got %0d want 0",
                 rs_if.writeBuffer_position);
      end
      checks++;
      if (rs_if.writeBuffer_value !== 32'd0) begin
        errors++;
        $display("FAIL reset_val got %0h want 0",
                 rs_if.writeBuffer_value);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_add;
    int ops [2] = '{1, 2};
    foreach (ops[i]) begin
      drive(ops[i], 0, 0, 5, 0, 7);
      checks++;
      if (rs_if.busy !== 1'b1 ||
          rs_if.writeBuffer_position !== 4'd0 ||
          rs_if.writeBuffer_value !== 32'd12) begin
        errors++;
        $display("FAIL add op%0d got %0b/%0d/%0d want 1/0/12",
                 ops[i], rs_if.busy,
                 rs_if.writeBuffer_position,
                 rs_if.writeBuffer_value);
      end
    end
  endtask

  task automatic test_sub_mul;
    int          ops [3] = '{3, 4, 5};
    logic [31:0] want [3] =
      '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd35};
    foreach (ops[i]) begin
      drive(ops[i], i + 1, 0, 5, 0, 7);
      checks++;
      if (rs_if.busy !== 1'b1 ||
          rs_if.writeBuffer_position !== 4'(i + 1) ||
          rs_if.writeBuffer_value !== want[i]) begin
        errors++;
        $display("FAIL submul op%0d got %0b/%0d/%h want 1/%0d/%h",
                 ops[i], rs_if.busy,
                 rs_if.writeBuffer_position,
                 rs_if.writeBuffer_value, i + 1, want[i]);
      end
    end
  endtask

  task automatic test_bge_shift;
    int          ops [6] = '{6, 6, 7, 8, 7, 6};
    logic [31:0] ja [6] =
      '{32'd7, 32'd1, 32'd5, 32'd5, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] kb [6] =
      '{32'd1, 32'd7, 32'd7, 32'd1, 32'd33, 32'd1};
    logic [31:0] want [6] =
      '{32'd0, 32'd1, 32'd640, 32'd2, 32'd2, 32'd1};
    foreach (ops[i]) begin
      drive(ops[i], 3, 0, ja[i], 0, kb[i]);
      checks++;
      if (rs_if.busy !== 1'b1 ||
          rs_if.writeBuffer_value !== want[i]) begin
        errors++;
        $display("FAIL bgeshift#%0d got %0b/%h want 1/%h",
                 i, rs_if.busy,
                 rs_if.writeBuffer_value, want[i]);
      end
    end
  endtask

  task automatic test_cdb;
    cdb[3]  = 32'd100;
    cdb[15] = 32'd200;
    drive(1, 1, 3, 32'd0, 0, 32'd1);
    checks++;
    if (rs_if.writeBuffer_value !== 32'd101) begin
      errors++;
      $display("FAIL cdb_qj got %0d want 101",
               rs_if.writeBuffer_value);
    end
    drive(1, 1, 0, 32'd1, 15, 32'd999);
    checks++;
    if (rs_if.writeBuffer_value !== 32'd201) begin
      errors++;
      $display("FAIL cdb_qk got %0d want 201",
               rs_if.writeBuffer_value);
    end
    drive(3, 4, 15, 32'd7, 3, 32'd7);
    checks++;
    if (rs_if.writeBuffer_value !== 32'd100) begin
      errors++;
      $display("FAIL cdb_both got %0d want 100",
               rs_if.writeBuffer_value);
    end
  endtask

  task automatic test_back_to_back;
    drive(1, 2, 0, 5, 0, 7);
    checks++;
    if (rs_if.busy !== 1'b1 ||
        rs_if.writeBuffer_position !== 4'd2 ||
        rs_if.writeBuffer_value !== 32'd12) begin
      errors++;
      $display("FAIL b2b_first got %0b/%0d/%0d want 1/2/12",
               rs_if.busy, rs_if.writeBuffer_position,
               rs_if.writeBuffer_value);
    end
    drive(3, 5, 0, 5, 0, 7);
    checks++;
    if (rs_if.busy !== 1'b1 ||
        rs_if.writeBuffer_position !== 4'd5 ||
        rs_if.writeBuffer_value !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL b2b_second got %0b/%0d/%h want 1/5/fffffffe",
               rs_if.busy, rs_if.writeBuffer_position,
               rs_if.writeBuffer_value);
    end
    drive(0, 9, 0, 1, 0, 1);
    checks++;
    if (rs_if.busy !== 1'b0 ||
        rs_if.writeBuffer_position !== 4'd5 ||
        rs_if.writeBuffer_value !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL nop_hold got %0b/%0d/%h want 0/5/fffffffe",
               rs_if.busy, rs_if.writeBuffer_position,
               rs_if.writeBuffer_value);
    end
    drive(9, 11, 0, 1, 0, 1);
    checks++;
    if (rs_if.busy !== 1'b0 ||
        rs_if.writeBuffer_position !== 4'd5) begin
      errors++;
      $display("FAIL undef_op got %0b/%0d want 0/5",
               rs_if.busy, rs_if.writeBuffer_position);
    end
  endtask

  task automatic test_reset_mid;
    drive(1, 7, 0, 3, 0, 4);
    checks++;
    if (rs_if.busy !== 1'b1 ||
        rs_if.writeBuffer_value !== 32'd7) begin
      errors++;
      $display("FAIL mid_pre got %0b/%0d want 1/7",
               rs_if.busy, rs_if.writeBuffer_value);
    end
    reset = 1'b0;
    drive(5, 6, 0, 3, 0, 4);
    checks++;
    if (rs_if.busy !== 1'b0 ||
        rs_if.writeBuffer_position !== 4'd0 ||
        rs_if.writeBuffer_value !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset got %0b/%0d/%0d want 0/0/0",
               rs_if.busy, rs_if.writeBuffer_position,
               rs_if.writeBuffer_value);
    end
    reset = 1'b1;
  endtask

  task automatic test_random;
    for (int n = 0; n < 300; n++) begin
      int tj;
      int tk;
      for (int t = 0; t < 16; t++) cdb[t] = $urandom;
      tj = ($urandom_range(0, 1) == 0)
           ? 0 : $urandom_range(1, 15);
      tk = ($urandom_range(0, 1) == 0)
           ? 0 : $urandom_range(1, 15);
      drive($urandom_range(0, 11),
            $urandom_range(0, 15),
            tj, $urandom, tk,
            ($urandom_range(0, 3) == 0)
              ? 32'($urandom_range(0, 70))
              : $urandom);
      checks++;
      if (rs_if.busy !== exp_busy ||
          rs_if.writeBuffer_position !== exp_pos ||
          rs_if.writeBuffer_value !== exp_val) begin
        errors++;
        $display("FAIL random#%0d got %0b/%0d/%h want %0b/%0d/%h",
                 n, rs_if.busy,
                 rs_if.writeBuffer_position,
                 rs_if.writeBuffer_value,
                 exp_busy, exp_pos, exp_val);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    for (int t = 0; t < 16; t++) cdb[t] = 32'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_sub_mul();
    test_bge_shift();
    test_cdb();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
